// File: rtl/router_wr_port_p.sv
// Router write port: frames a header/payload/parity byte stream and writes it
// into one of NUM_CH downstream FIFOs. It drives busy when the selected FIFO
// is full, checks parity and length, and drops packets whose address is out
// of range.
module router_wr_port_p #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  input  logic [NUM_CH-1:0] ch_full,
  output logic [NUM_CH-1:0] ch_we,
  output logic [DATA_W-1:0] ch_wdata,
  output logic              error,
  output logic              addr_err,
  output logic              pkt_done
);

  localparam int ADDR_W = $clog2(NUM_CH);
  localparam int LEN_W  = DATA_W - ADDR_W;
  localparam int PAD_CH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NUM_CH_L = (ADDR_W+1)'(NUM_CH);
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, PAYLOAD, DROP, CHECK} state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] sel_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  count_reg;
  logic              sat_reg;
  logic [DATA_W-1:0] parity_reg;
  logic [DATA_W-1:0] rx_parity_reg;
  logic              error_reg;
  logic              addr_err_reg;

  // Header fields are decoded straight from the input byte.
  logic [ADDR_W-1:0] hdr_addr;
  logic [LEN_W-1:0]  hdr_len;
  logic              addr_ok;
  logic [PAD_CH-1:0] full_pad;

  assign hdr_addr = data_in[ADDR_W-1:0];
  assign hdr_len  = data_in[DATA_W-1:ADDR_W];
  assign addr_ok  = ({1'b0, hdr_addr} < NUM_CH_L);
  // Padding to a power of two lets an out-of-range address index safely.
  assign full_pad = PAD_CH'(ch_full);

  logic              busy_c;
  logic              we_en;
  logic [ADDR_W-1:0] we_sel;
  logic              hdr_accept;
  logic              bad_hdr;
  logic              pay_accept;

  // Compute the next state, stall and write strobes for the current byte.
  always_comb begin
    state_next = state_reg;
    busy_c     = 1'b0;
    we_en      = 1'b0;
    we_sel     = sel_reg;
    hdr_accept = 1'b0;
    bad_hdr    = 1'b0;
    pay_accept = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pkt_valid) begin
          if (!addr_ok) begin
            bad_hdr    = 1'b1;
            state_next = DROP;
          end else if (full_pad[hdr_addr]) begin
            busy_c = 1'b1;
          end else begin
            hdr_accept = 1'b1;
            we_en      = 1'b1;
            we_sel     = hdr_addr;
            state_next = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        busy_c = full_pad[sel_reg];
        if (!full_pad[sel_reg]) begin
          pay_accept = 1'b1;
          we_en      = 1'b1;
          if (!pkt_valid) state_next = CHECK;
        end
      end
      DROP: begin
        if (!pkt_valid) state_next = IDLE;
      end
      CHECK: begin
        busy_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, independent of the clock.
  assign busy     = busy_c & ~reset;
  assign ch_wdata = data_in;
  assign error    = error_reg;
  assign addr_err = addr_err_reg;
  assign pkt_done = (state_reg == CHECK);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_we
      assign ch_we[gi] = we_en & ~reset & (we_sel == ADDR_W'(gi));
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Header latch, running parity and length count, and the error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_reg       <= '0;
      len_reg       <= '0;
      count_reg     <= '0;
      sat_reg       <= 1'b0;
      parity_reg    <= '0;
      rx_parity_reg <= '0;
      error_reg     <= 1'b0;
      addr_err_reg  <= 1'b0;
    end else begin
      addr_err_reg <= bad_hdr;
      if (hdr_accept) begin
        sel_reg    <= hdr_addr;
        len_reg    <= hdr_len;
        parity_reg <= data_in;
        count_reg  <= '0;
        sat_reg    <= 1'b0;
        error_reg  <= 1'b0;
      end
      if (pay_accept) begin
        if (pkt_valid) begin
          parity_reg <= parity_reg ^ data_in;
          if (count_reg == CNT_MAX) sat_reg   <= 1'b1;
          else                      count_reg <= count_reg + 1'b1;
        end else begin
          rx_parity_reg <= data_in;
        end
      end
      if (state_reg == CHECK) begin
        error_reg <= (parity_reg != rx_parity_reg) | (count_reg != len_reg) | sat_reg;
      end
    end
  end

endmodule

// File: tb/tb_router_wr_port_p.sv
// Directed testbench for router_wr_port_p (DATA_W=8, NUM_CH=3).
// Inputs change on the falling edge; outputs are sampled 1 ns later, before
// the next rising edge. Each vector's expected value is the concatenation
// {ch_we, busy, pkt_done, error, addr_err}.
module tb_router_wr_port_p;

  logic       clk;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       busy;
  logic [2:0] ch_full;
  logic [2:0] ch_we;
  logic [7:0] ch_wdata;
  logic       error;
  logic       addr_err;
  logic       pkt_done;

  int vectors;
  int miscompares;

  router_wr_port_p #(.DATA_W(8), .NUM_CH(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .pkt_valid(pkt_valid),
    .data_in  (data_in),
    .busy     (busy),
    .ch_full  (ch_full),
    .ch_we    (ch_we),
    .ch_wdata (ch_wdata),
    .error    (error),
    .addr_err (addr_err),
    .pkt_done (pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] obs;
  assign obs = {ch_we, busy, pkt_done, error, addr_err};

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [2:0] full;
    logic [6:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [2:0] f,
                              input logic [2:0] we, input logic b, input logic dn,
                              input logic e, input logic a);
    vec_t r;
    r.valid = v;
    r.data  = d;
    r.full  = f;
    r.exp   = {we, b, dn, e, a};
    return r;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    pkt_valid = v.valid;
    data_in   = v.data;
    ch_full   = v.full;
    #1;
  endtask

  // Good packet to channel 1: header 0D (len 3, addr 1), parity 0D.
  task automatic add_good_pkt(inout vec_t q[$], input logic err_before);
    q.push_back(mk(1, 8'h0D, 3'b000, 3'b010, 0, 0, err_before, 0));
    q.push_back(mk(1, 8'h11, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(1, 8'h22, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(1, 8'h33, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(0, 8'h0D, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(0, 8'h00, 3'b000, 3'b000, 1, 1, 0, 0));
    q.push_back(mk(0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0));
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    ch_full   = 3'b000;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (obs !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %b want %b", obs, 7'b0);
    end else $display("vec reset_state ok obs=%b", obs);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_normal;
    vec_t q[$];
    add_good_pkt(q, 1'b0);
    foreach (q[i]) begin
      apply(q[i]);
      vectors++;
      if (obs !== q[i].exp) begin
        miscompares++;
        $display("FAIL normal[%0d]: got %b want %b", i, obs, q[i].exp);
      end else $display("vec normal[%0d] ok obs=%b", i, obs);
    end
  endtask

  task automatic test_bad_parity;
    vec_t q[$];
    q.push_back(mk(1, 8'h0D, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(1, 8'h11, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(1, 8'h22, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(1, 8'h33, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(0, 8'h0E, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(0, 8'h00, 3'b000, 3'b000, 1, 1, 0, 0));
    q.push_back(mk(0, 8'h00, 3'b000, 3'b000, 0, 0, 1, 0));
    q.push_back(mk(0, 8'h00, 3'b000, 3'b000, 0, 0, 1, 0));
    foreach (q[i]) begin
      apply(q[i]);
      vectors++;
      if (obs !== q[i].exp) begin
        miscompares++;
        $display("FAIL bad_parity[%0d]: got %b want %b", i, obs, q[i].exp);
      end else $display("vec bad_parity[%0d] ok obs=%b", i, obs);
    end
  endtask

  // Entered with error=1 from the bad-parity packet; the header clears it.
  task automatic test_backpressure;
    vec_t q[$];
    q.push_back(mk(1, 8'h0D, 3'b000, 3'b010, 0, 0, 1, 0));
    q.push_back(mk(1, 8'h11, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(1, 8'h22, 3'b101, 3'b010, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      q.push_back(mk(1, 8'h33, 3'b010, 3'b000, 1, 0, 0, 0));
    q.push_back(mk(1, 8'h33, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(0, 8'h0D, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(0, 8'h00, 3'b000, 3'b000, 1, 1, 0, 0));
    q.push_back(mk(0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      vectors++;
      if (obs !== q[i].exp) begin
        miscompares++;
        $display("FAIL backpressure[%0d]: got %b want %b", i, obs, q[i].exp);
      end else $display("vec backpressure[%0d] ok obs=%b", i, obs);
    end
  endtask

  // Short packet (parity 3E is correct for 0D^11^22), then a zero-length
  // packet to channel 2 that first waits on ch_full[2].
  task automatic test_length;
    vec_t q[$];
    q.push_back(mk(1, 8'h0D, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(1, 8'h11, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(1, 8'h22, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(0, 8'h3E, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(0, 8'h00, 3'b000, 3'b000, 1, 1, 0, 0));
    q.push_back(mk(0, 8'h00, 3'b000, 3'b000, 0, 0, 1, 0));
    q.push_back(mk(1, 8'h02, 3'b100, 3'b000, 1, 0, 1, 0));
    q.push_back(mk(1, 8'h02, 3'b011, 3'b100, 0, 0, 1, 0));
    q.push_back(mk(0, 8'h02, 3'b011, 3'b100, 0, 0, 0, 0));
    q.push_back(mk(0, 8'h00, 3'b000, 3'b000, 1, 1, 0, 0));
    q.push_back(mk(0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      vectors++;
      if (obs !== q[i].exp) begin
        miscompares++;
        $display("FAIL length[%0d]: got %b want %b", i, obs, q[i].exp);
      end else $display("vec length[%0d] ok obs=%b", i, obs);
    end
  endtask

  task automatic test_bad_addr;
    vec_t q[$];
    q.push_back(mk(1, 8'h07, 3'b000, 3'b000, 0, 0, 0, 0));
    q.push_back(mk(1, 8'hAA, 3'b000, 3'b000, 0, 0, 0, 1));
    q.push_back(mk(1, 8'hBB, 3'b000, 3'b000, 0, 0, 0, 0));
    q.push_back(mk(0, 8'hCC, 3'b000, 3'b000, 0, 0, 0, 0));
    q.push_back(mk(1, 8'h0D, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(1, 8'h11, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(1, 8'h22, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(1, 8'h33, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(0, 8'h0D, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(0, 8'h00, 3'b000, 3'b000, 1, 1, 0, 0));
    q.push_back(mk(0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      vectors++;
      if (obs !== q[i].exp) begin
        miscompares++;
        $display("FAIL bad_addr[%0d]: got %b want %b", i, obs, q[i].exp);
      end else $display("vec bad_addr[%0d] ok obs=%b", i, obs);
    end
  endtask

  task automatic test_reset_mid;
    vec_t q[$];
    q.push_back(mk(1, 8'h0D, 3'b000, 3'b010, 0, 0, 0, 0));
    q.push_back(mk(1, 8'h11, 3'b000, 3'b010, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      vectors++;
      if (obs !== q[i].exp) begin
        miscompares++;
        $display("FAIL reset_mid_pre[%0d]: got %b want %b", i, obs, q[i].exp);
      end else $display("vec reset_mid_pre[%0d] ok obs=%b", i, obs);
    end
    // Assert reset between clock edges with a valid-looking header on the bus.
    @(negedge clk);
    reset     = 1'b1;
    pkt_valid = 1'b1;
    data_in   = 8'h22;
    #1;
    vectors++;
    if (obs !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got %b want %b", obs, 7'b0);
    end else $display("vec reset_mid_async ok obs=%b", obs);
    @(posedge clk);
    #1;
    vectors++;
    if (obs !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_mid_held: got %b want %b", obs, 7'b0);
    end else $display("vec reset_mid_held ok obs=%b", obs);
    @(negedge clk);
    reset     = 1'b0;
    pkt_valid = 1'b0;
    q.delete();
    add_good_pkt(q, 1'b0);
    foreach (q[i]) begin
      apply(q[i]);
      vectors++;
      if (obs !== q[i].exp) begin
        miscompares++;
        $display("FAIL reset_mid_post[%0d]: got %b want %b", i, obs, q[i].exp);
      end else $display("vec reset_mid_post[%0d] ok obs=%b", i, obs);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_normal();
    test_bad_parity();
    test_backpressure();
    test_length();
    test_bad_addr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
